// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter sequencer with halt, branch, wrap flag and cycle counter
module instr_fetch #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_i,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic             zero_i,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc_o,
  output logic             instr_valid,
  output logic             done,
  output logic             pc_ovf,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ZERO  = '0;
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic             w_done_nxt;
  logic             w_ovf_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_taken;
  logic             w_pc_at_max;
  logic [PC_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0] w_cnt_inc;

  // Branch resolution, sequential pc and saturating count used while running
  always_comb begin
    w_taken     = branch_en & (~branch_cond | zero_i);
    w_pc_at_max = &r_pc;
    w_pc_inc    = r_pc + PC_ONE;
    w_cnt_inc   = (&r_cnt) ? r_cnt : (r_cnt + CNT_ONE);
  end

  // Next-state and next-output selection; abort beats halt beats branch beats increment
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = r_done;
    w_ovf_nxt   = r_ovf;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_pc_nxt   = PC_ZERO;
        w_cnt_nxt  = CNT_ZERO;
        w_ovf_nxt  = 1'b0;
        w_done_nxt = 1'b0;
        if (!start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (start) begin
          // abort: the running count is discarded along with the pc
          w_state_nxt = S_IDLE;
          w_pc_nxt    = PC_ZERO;
          w_cnt_nxt   = CNT_ZERO;
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b0;
        end else if (halt_i) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (w_taken) begin
          // a branch onto the current pc is a self-loop, never a wrap
          w_pc_nxt = target;
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_ovf_nxt = r_ovf | w_pc_at_max;
        end
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        if (start) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = PC_ZERO;
          w_cnt_nxt   = CNT_ZERO;
          w_ovf_nxt   = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = PC_ZERO;
        w_cnt_nxt   = CNT_ZERO;
        w_ovf_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= PC_ZERO;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_o        = r_pc;
  assign done        = r_done;
  assign pc_ovf      = r_ovf;
  assign cycle_cnt   = r_cnt;
  assign instr_valid = (r_state == S_RUN);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - vector table and hand sequences for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_i, branch_en, branch_cond, zero_i;
  logic [9:0]  target;
  logic [9:0]  pc_o;
  logic        instr_valid, done, pc_ovf;
  logic [15:0] cycle_cnt;

  logic        s_start;
  logic        s_zero = 1'b0;
  logic [9:0]  s_target = 10'd0;
  logic [9:0]  s_pc;
  logic        s_valid, s_done, s_ovf;
  logic [3:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_W(10), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_i(halt_i),
    .branch_en(branch_en), .branch_cond(branch_cond), .zero_i(zero_i),
    .target(target), .pc_o(pc_o), .instr_valid(instr_valid), .done(done),
    .pc_ovf(pc_ovf), .cycle_cnt(cycle_cnt)
  );

  instr_fetch #(.PC_W(10), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .halt_i(s_zero),
    .branch_en(s_zero), .branch_cond(s_zero), .zero_i(s_zero),
    .target(s_target), .pc_o(s_pc), .instr_valid(s_valid), .done(s_done),
    .pc_ovf(s_ovf), .cycle_cnt(s_cnt)
  );

  typedef struct {
    logic        st, hl, be, bc, z;
    logic [9:0]  tgt;
    logic [9:0]  pc;
    logic        v, d, o;
    logic [15:0] c;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic hl, logic be, logic bc, logic z,
                              logic [9:0] tgt, logic [9:0] pc, logic v,
                              logic d, logic o, logic [15:0] c);
    vec_t r;
    r.st = st; r.hl = hl; r.be = be; r.bc = bc; r.z = z; r.tgt = tgt;
    r.pc = pc; r.v = v; r.d = d; r.o = o; r.c = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string tag, input logic [9:0] pc, input logic v,
                            input logic d, input logic o, input logic [15:0] c);
    check({tag, ".pc"}, 32'(pc_o), 32'(pc));
    check({tag, ".valid"}, 32'(instr_valid), 32'(v));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".ovf"}, 32'(pc_ovf), 32'(o));
    check({tag, ".cnt"}, 32'(cycle_cnt), 32'(c));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic hl, input logic be,
                       input logic bc, input logic z, input logic [9:0] tgt);
    start = st; halt_i = hl; branch_en = be; branch_cond = bc; zero_i = z; target = tgt;
  endtask

  initial begin
    //        st hl be bc z  tgt     pc    v  d  o  cnt
    vq.push_back(mk(1, 0, 0, 0, 0, 10'd0,   10'd0,   0, 0, 0, 16'd0));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   1, 0, 0, 16'd0));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd1,   1, 0, 0, 16'd1));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd2,   1, 0, 0, 16'd2));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd3,   1, 0, 0, 16'd3));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd4,   1, 0, 0, 16'd4));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd5,   1, 0, 0, 16'd5));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd6,   1, 0, 0, 16'd6));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd7,   1, 0, 0, 16'd7));
    vq.push_back(mk(0, 0, 1, 1, 0, 10'd20,  10'd8,   1, 0, 0, 16'd8));
    vq.push_back(mk(0, 0, 1, 0, 0, 10'd7,   10'd7,   1, 0, 0, 16'd9));
    vq.push_back(mk(0, 0, 1, 1, 1, 10'd20,  10'd20,  1, 0, 0, 16'd10));
    vq.push_back(mk(0, 0, 1, 0, 0, 10'd12,  10'd12,  1, 0, 0, 16'd11));
    vq.push_back(mk(0, 0, 1, 0, 1, 10'd12,  10'd12,  1, 0, 0, 16'd12));
    vq.push_back(mk(0, 1, 1, 0, 0, 10'd50,  10'd12,  0, 1, 0, 16'd13));
    vq.push_back(mk(0, 1, 1, 0, 1, 10'd99,  10'd12,  0, 1, 0, 16'd13));
    vq.push_back(mk(1, 0, 0, 0, 0, 10'd0,   10'd0,   0, 0, 0, 16'd0));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   1, 0, 0, 16'd0));
    vq.push_back(mk(0, 0, 1, 0, 0, 10'd1023,10'd1023,1, 0, 0, 16'd1));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   1, 0, 1, 16'd2));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd1,   1, 0, 1, 16'd3));
    vq.push_back(mk(0, 0, 1, 0, 0, 10'd1,   10'd1,   1, 0, 1, 16'd4));
    vq.push_back(mk(1, 0, 0, 0, 0, 10'd0,   10'd0,   0, 0, 0, 16'd0));
    vq.push_back(mk(1, 1, 1, 0, 0, 10'd5,   10'd0,   0, 0, 0, 16'd0));
    vq.push_back(mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   1, 0, 0, 16'd0));
    vq.push_back(mk(0, 1, 0, 0, 0, 10'd0,   10'd0,   0, 1, 0, 16'd1));
    vq.push_back(mk(0, 1, 1, 0, 1, 10'd3,   10'd0,   0, 1, 0, 16'd1));

    rst_n = 1'b0; s_start = 1'b1;
    drive(1, 0, 0, 0, 0, 10'd0);
    #2;
    check_main("reset_async", 10'd0, 0, 0, 0, 16'd0);
    step();
    step();
    check_main("reset_held", 10'd0, 0, 0, 0, 16'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].hl, vq[i].be, vq[i].bc, vq[i].z, vq[i].tgt);
      step();
      check_main($sformatf("vec%0d", i), vq[i].pc, vq[i].v, vq[i].d, vq[i].o, vq[i].c);
    end

    // reach pc 9 in RUN, then pulse reset between edges
    drive(1, 0, 0, 0, 0, 10'd0);
    step();
    drive(0, 0, 0, 0, 0, 10'd0);
    for (int k = 0; k < 10; k++) step();
    check_main("run_pc9", 10'd9, 1, 0, 0, 16'd9);
    #2 rst_n = 1'b0;
    #1 check_main("rst_mid_run", 10'd0, 0, 0, 0, 16'd0);
    #1 rst_n = 1'b1;
    step();
    check_main("rst_resume0", 10'd0, 1, 0, 0, 16'd0);
    step();
    check_main("rst_resume1", 10'd1, 1, 0, 0, 16'd1);

    // reset while in DONE
    drive(0, 1, 0, 0, 0, 10'd0);
    step();
    check_main("halt_pc1", 10'd1, 0, 1, 0, 16'd2);
    drive(1, 0, 0, 0, 0, 10'd0);
    #2 rst_n = 1'b0;
    #1 check_main("rst_in_done", 10'd0, 0, 0, 0, 16'd0);
    #1 rst_n = 1'b1;
    step();
    check_main("idle_after_rst", 10'd0, 0, 0, 0, 16'd0);

    // 4-bit counter saturation: one edge to enter RUN, then 20 running cycles
    check("sat.idle_cnt", 32'(s_cnt), 32'd0);
    s_start = 1'b0;
    step();
    check("sat.enter_valid", 32'(s_valid), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("sat.cnt%0d", k), 32'(s_cnt), (k > 15) ? 32'd15 : 32'(k));
    end
    check("sat.pc", 32'(s_pc), 32'd20);
    check("sat.done", 32'(s_done), 32'd0);
    check("sat.ovf", 32'(s_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning program-counter and instruction-ROM address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning cycle-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level request from bench: high = hold/restart, falling edge = begin execution.
REQ-006 SHALL have port halt_i  input  1  decoded halt instruction at current pc.
REQ-007 SHALL have port branch_en  input  1  decoded branch instruction at current pc.
REQ-008 SHALL have port branch_cond  input  1  0 = unconditional, 1 = taken only when zero_i is high.
REQ-009 SHALL have port zero_i  input  1  registered ALU zero flag from the previous instruction.
REQ-010 SHALL have port target  input  PC_W  absolute branch destination.
REQ-011 SHALL have port pc_o  output  PC_W  instruction-ROM address.
REQ-012 SHALL have port instr_valid  output  1  high when the instruction at pc_o is executed this cycle.
REQ-013 SHALL have port done  output  1  program finished; held until restart.
REQ-014 SHALL have port pc_ovf  output  1  sticky flag: pc wrapped past its maximum.
REQ-015 SHALL have port cycle_cnt  output  CNT_W  number of executed instructions since last start.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, RUN, DONE; state and all outputs registered, except instr_valid = (state==RUN).
REQ-017 IDLE: pc_o=0, cycle_cnt=0, pc_ovf=0, done=0; SHALL move to RUN on the first cycle start is sampled low.
REQ-018 RUN, priority 1: start high -> IDLE next cycle, pc_o=0, cycle_cnt=0, pc_ovf=0 (abort).
REQ-019 RUN, priority 2: halt_i high -> DONE next cycle, pc_o held, done=1; halt_i SHALL override a simultaneous branch_en.
REQ-020 RUN, priority 3: taken = branch_en & (~branch_cond | zero_i); taken -> pc_o=target next cycle.
REQ-021 RUN, priority 4: otherwise pc_o = pc_o+1, modulo 2^PC_W.
REQ-022 Increment from 2^PC_W-1 SHALL wrap pc_o to 0, set pc_ovf=1, and stay in RUN.
REQ-023 A taken branch to target = pc_o SHALL hold pc_o (legal self-loop); it SHALL NOT set pc_ovf.
REQ-024 cycle_cnt SHALL increment by 1 each RUN cycle, including halting, branching and aborting cycles.
REQ-025 cycle_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-026 DONE: pc_o, cycle_cnt and pc_ovf SHALL be held, done=1; halt_i, branch_en and zero_i SHALL be ignored.
REQ-027 DONE: start high -> IDLE next cycle, done=0, pc_o=0, cycle_cnt=0.
REQ-028 In IDLE and DONE, branch_en, halt_i and target SHALL have no effect.
REQ-029 Latency SHALL be one cycle: the pc_o change and the state change appear the edge after the inputs are sampled.

Reset
REQ-030 rst_n low SHALL immediately, without a clock edge, force state=IDLE, pc_o=0, done=0, pc_ovf=0, cycle_cnt=0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL discard all progress.
REQ-032 After rst_n rises, the block SHALL remain in IDLE while start is high and enter RUN on the first edge with start low.

Verification
REQ-033 Reset, start 1->0, halt_i=0, branch_en=0 for 5 cycles -> pc_o 0,1,2,3,4,5; instr_valid=1; cycle_cnt=5.
REQ-034 In RUN at pc_o=7: branch_en=1, branch_cond=1, zero_i=0, target=20 -> pc_o=8; repeat with zero_i=1 -> pc_o=20.
REQ-035 In RUN at pc_o=12: halt_i=1 and branch_en=1 together -> DONE, done=1, pc_o=12; then start=1 -> IDLE, done=0, pc_o=0, cycle_cnt=0.
REQ-036 Branch to target=1023, one idle cycle -> pc_o=0, pc_ovf=1, state RUN.
REQ-037 rst_n pulsed low between clock edges during RUN at pc_o=9 -> pc_o=0 and done=0 immediately; with start low, RUN resumes from pc_o=0 after rst_n rises.
REQ-038 CNT_W=4, run 20 cycles without halt -> cycle_cnt saturates at 15.
